noc_router_xy_wormhole: RTL and testbench

- Next-generation mesh router with input-buffered wormhole switching and one clock domain.
- Head flits are routed dimension-ordered (XY) from the destination field.
- Each output is owned by one input from head flit to tail flit.
- Output arbitration is configurable: fixed priority or round-robin.
- Instantiated once per mesh node; the network tile wrapper connects it to neighbour routers and to the local network interface.

---
 rtl/noc_router_xy_wormhole_pkg.sv | 69 ++++++
 rtl/noc_router_xy_wormhole_fifo.sv | 60 ++++++
 rtl/noc_router_xy_wormhole.sv | 160 ++++++++++++++++
 tb/tb_noc_router_xy_wormhole.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_router_xy_wormhole_pkg.sv
`default_nettype none
// ============================================================================
// Package  : noc_pkg
// Purpose  : Shared flit encodings, port indices and routing/arbitration
//            helper functions for the XY wormhole mesh router.
// Revision : 1.0 - initial release
// ============================================================================
package noc_pkg;

  // Flit type field encodings
  localparam logic [1:0] FLIT_BODY     = 2'b00;
  localparam logic [1:0] FLIT_HEAD     = 2'b01;
  localparam logic [1:0] FLIT_TAIL     = 2'b10;
  localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

  localparam int NUM_PORTS = 5;
  localparam int PORT_W    = 3;

  typedef logic [PORT_W-1:0] port_idx_t;

  // Fixed port order shared by all routers of the mesh
  localparam port_idx_t LOCAL = 3'd0;
  localparam port_idx_t NORTH = 3'd1;
  localparam port_idx_t EAST  = 3'd2;
  localparam port_idx_t SOUTH = 3'd3;
  localparam port_idx_t WEST  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GRANT = 2'd1,
    ST_FORWARD    = 2'd2
  } in_state_t;

  // Dimension-ordered route: resolve X first, then Y, else deliver locally
  function automatic port_idx_t xy_route(input int unsigned dest,
                                         input int unsigned index,
                                         input int unsigned n);
    int unsigned dx, dy, x, y;
    dx = dest % n;
    dy = dest / n;
    x  = index % n;
    y  = index / n;
    if (dx > x)      return EAST;
    else if (dx < x) return WEST;
    else if (dy < y) return NORTH;
    else if (dy > y) return SOUTH;
    else             return LOCAL;
  endfunction

  // First requester found when scanning upward (with wrap) from ptr
  function automatic port_idx_t rr_pick(input logic [NUM_PORTS-1:0] req,
                                        input port_idx_t ptr);
    port_idx_t pick;
    port_idx_t idx;
    logic      found;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = port_idx_t'((int'(ptr) + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/noc_router_xy_wormhole_fifo.sv
`default_nettype none
// ============================================================================
// Module   : noc_input_fifo
// Purpose  : Per-input synchronous flit buffer with full/empty status.
//            Writes are refused while full even if a read happens together.
// Revision : 1.0 - initial release
// ============================================================================
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] front,
  output logic             full,
  output logic             empty
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign front   = mem[rd_ptr];

  // Storage array; contents need no reset since count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/noc_router_xy_wormhole.sv
`default_nettype none
// ============================================================================
// Module   : noc_router_xy_wormhole
// Purpose  : Input-buffered wormhole mesh router with XY routing, per-output
//            packet locks and fixed-priority or round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module noc_router_xy_wormhole
  import noc_pkg::*;
#(
  parameter int N          = 4,
  parameter int INDEX      = 0,
  parameter int PORTS      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int DEST_WIDTH = $clog2(N*N),
  parameter int FIFO_DEPTH = 8,
  parameter int ARB_MODE   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] data_in,
  input  logic [PORTS-1:0]            valid_in,
  output logic [PORTS-1:0]            ready_in,
  output logic [PORTS*DATA_WIDTH-1:0] data_out,
  output logic [PORTS-1:0]            valid_out,
  input  logic [PORTS-1:0]            ready_out,
  output logic [PORTS-1:0]            err_out
);

  localparam int NODES = N * N;

  logic [DATA_WIDTH-1:0] front [PORTS];
  logic [PORTS-1:0]      fifo_empty;
  logic [PORTS-1:0]      fifo_full;
  logic [PORTS-1:0]      fifo_pop;
  logic [PORTS-1:0]      is_head;
  logic [PORTS-1:0]      is_tail;
  logic [PORTS-1:0]      dest_ok;
  logic [PORTS-1:0]      discard;
  logic [PORTS-1:0]      grant_in;
  port_idx_t             route [PORTS];

  in_state_t             state      [PORTS];
  in_state_t             state_next [PORTS];

  logic [PORTS-1:0]      locked;
  port_idx_t             owner  [PORTS];
  port_idx_t             rr_ptr [PORTS];
  logic [PORTS-1:0]      req    [PORTS];
  port_idx_t             winner [PORTS];
  logic [PORTS-1:0]      do_grant;
  logic [PORTS-1:0]      out_fire;
  logic [PORTS-1:0]      err;

  assign ready_in = ~fifo_full;
  assign err_out  = err;

  generate
    for (genvar i = 0; i < PORTS; i++) begin : g_in
      logic [DEST_WIDTH-1:0] dest_f;

      noc_input_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (valid_in[i]),
        .push_data (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
        .pop       (fifo_pop[i]),
        .front     (front[i]),
        .full      (fifo_full[i]),
        .empty     (fifo_empty[i])
      );

      // Type bit 0 marks a head (HEAD/HEADTAIL), bit 1 a tail (TAIL/HEADTAIL)
      assign is_head[i] = front[i][DATA_WIDTH-TYPE_WIDTH];
      assign is_tail[i] = front[i][DATA_WIDTH-TYPE_WIDTH+1];
      assign dest_f     = front[i][DEST_WIDTH-1:0];
      assign dest_ok[i] = (32'(dest_f) < NODES);
      assign route[i]   = xy_route(32'(dest_f), INDEX, N);

      // Non-heads and unroutable heads at an idle input are dropped, which
      // also drains the orphan flits that trail a bad head
      assign discard[i] = (state[i] == ST_IDLE) && !fifo_empty[i] &&
                          (!is_head[i] || !dest_ok[i]);
    end
  endgenerate

  // Per-input state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORTS; i++) begin
      if (rst) state[i] <= ST_IDLE;
      else     state[i] <= state_next[i];
    end
  end

  // Per-input next state: wait for a valid head, hold until granted, forward to tail
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      state_next[i] = state[i];
      case (state[i])
        ST_IDLE:       if (!fifo_empty[i] && is_head[i] && dest_ok[i]) state_next[i] = ST_WAIT_GRANT;
        ST_WAIT_GRANT: if (grant_in[i]) state_next[i] = ST_FORWARD;
        ST_FORWARD:    if (fifo_pop[i] && is_tail[i]) state_next[i] = ST_IDLE;
        default:       state_next[i] = ST_IDLE;
      endcase
    end
  end

  // Request matrix and arbitration for every unlocked output
  always_comb begin
    grant_in = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        req[o][i] = (state[i] == ST_WAIT_GRANT) && (route[i] == port_idx_t'(o));
      end
      do_grant[o] = !locked[o] && (|req[o]);
      winner[o]   = (ARB_MODE == 1) ? rr_pick(req[o], rr_ptr[o]) : rr_pick(req[o], '0);
      if (do_grant[o]) grant_in[winner[o]] = 1'b1;
    end
  end

  // Crossbar: a locked output streams its owner's FIFO front; pops from outputs and discards merge
  always_comb begin
    fifo_pop = discard;
    for (int o = 0; o < PORTS; o++) begin
      valid_out[o] = locked[o] && !fifo_empty[owner[o]];
      data_out[o*DATA_WIDTH +: DATA_WIDTH] = valid_out[o] ? front[owner[o]] : '0;
      out_fire[o] = valid_out[o] && ready_out[o];
      if (out_fire[o]) fifo_pop[owner[o]] = 1'b1;
    end
  end

  // Output locks: taken on grant, released when the owner's tail leaves
  always_ff @(posedge clk) begin
    for (int o = 0; o < PORTS; o++) begin
      if (rst) begin
        locked[o] <= 1'b0;
        owner[o]  <= '0;
        rr_ptr[o] <= '0;
      end else if (locked[o]) begin
        if (out_fire[o] && is_tail[owner[o]]) locked[o] <= 1'b0;
      end else if (do_grant[o]) begin
        locked[o] <= 1'b1;
        owner[o]  <= winner[o];
        rr_ptr[o] <= (winner[o] == port_idx_t'(PORTS-1)) ? '0 : winner[o] + 3'd1;
      end
    end
  end

  // Sticky protocol-error flags, one per input
  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= err | discard;
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_router_xy_wormhole.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_router_xy_wormhole
// Purpose  : Directed self-checking bench for the XY wormhole router at node
//            5 of a 4x4 mesh; a round-robin and a fixed-priority instance
//            share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_router_xy_wormhole;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic         clk;
  logic         rst;
  logic [159:0] data_in;
  logic [4:0]   valid_in;
  logic [4:0]   ready_out;
  logic [4:0]   ready_in,  fp_ready_in;
  logic [159:0] data_out,  fp_data_out;
  logic [4:0]   valid_out, fp_valid_out;
  logic [4:0]   err_out,   fp_err_out;

  int n_tests = 0;
  int n_fail  = 0;

  noc_router_xy_wormhole #(
    .N(4), .INDEX(5), .PORTS(5), .DATA_WIDTH(32), .TYPE_WIDTH(2),
    .DEST_WIDTH(5), .FIFO_DEPTH(8), .ARB_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out),
    .ready_out(ready_out), .err_out(err_out)
  );

  noc_router_xy_wormhole #(
    .N(4), .INDEX(5), .PORTS(5), .DATA_WIDTH(32), .TYPE_WIDTH(2),
    .DEST_WIDTH(5), .FIFO_DEPTH(8), .ARB_MODE(0)
  ) dut_fp (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_in(fp_ready_in), .data_out(fp_data_out), .valid_out(fp_valid_out),
    .ready_out(ready_out), .err_out(fp_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [24:0] tag, input logic [4:0] d);
    return {t, tag, d};
  endfunction

  function automatic logic [31:0] dout(input int p);
    return data_out[p*32 +: 32];
  endfunction

  function automatic logic [31:0] fp_dout(input int p);
    return fp_data_out[p*32 +: 32];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int p, input logic [31:0] f);
    data_in[p*32 +: 32] = f;
    valid_in[p] = 1'b1;
  endtask

  task automatic clr_in();
    valid_in = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [31:0] f;
  logic [31:0] pkt [4];
  logic [31:0] arb_exp [8];
  logic [4:0]  rt_dest [5];
  int          rt_port [5];

  initial begin
    rst = 1'b1; data_in = '0; valid_in = '0; ready_out = 5'b11111;
    step(); step();
    check("rst_ready_in", ready_in, 5'b11111);
    check("rst_valid_out", valid_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_err_out", err_out, 0);
    rst = 1'b0;

    // XY routing from node (1,1): single-flit packets on the local input
    rt_dest = '{5'd7, 5'd13, 5'd4, 5'd1, 5'd5};
    rt_port = '{2, 3, 4, 1, 0};
    for (int k = 0; k < 5; k++) begin
      f = mk(T_HT, 25'(k + 1), rt_dest[k]);
      set_in(0, f); step();
      clr_in(); step();
      check("route_early", valid_out, 0);
      step();
      check("route_valid", valid_out, 5'b1 << rt_port[k]);
      check("route_data", dout(rt_port[k]), f);
      step();
      check("route_done", valid_out, 0);
    end

    // 4-flit packet queued behind a stalled east output, then streamed back-to-back
    pkt[0] = mk(T_HEAD, 25'h100, 5'd7);
    pkt[1] = mk(T_BODY, 25'h101, 5'd7);
    pkt[2] = mk(T_BODY, 25'h102, 5'd7);
    pkt[3] = mk(T_TAIL, 25'h103, 5'd7);
    ready_out[2] = 1'b0;
    for (int j = 0; j < 4; j++) begin set_in(0, pkt[j]); step(); end
    clr_in();
    ready_out[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("pkt_valid", valid_out, 5'b00100);
      check("pkt_data", dout(2), pkt[j]);
      step();
    end
    check("pkt_released", valid_out, 0);

    // Backpressure mid-packet: body held stable for three cycles
    pkt[0] = mk(T_HEAD, 25'h200, 5'd7);
    pkt[1] = mk(T_BODY, 25'h201, 5'd7);
    pkt[2] = mk(T_BODY, 25'h202, 5'd7);
    pkt[3] = mk(T_TAIL, 25'h203, 5'd7);
    for (int j = 0; j < 4; j++) begin set_in(0, pkt[j]); step(); end
    clr_in();
    check("bp_first_body", dout(2), pkt[1]);
    ready_out[2] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      check("bp_hold_valid", valid_out, 5'b00100);
      check("bp_hold_data", dout(2), pkt[1]);
    end
    ready_out[2] = 1'b1;
    step(); check("bp_body2", dout(2), pkt[2]);
    step(); check("bp_tail", dout(2), pkt[3]);
    step(); check("bp_done", valid_out, 0);

    // Inputs 1 and 3 contend for the local output with two packets each
    arb_exp[0] = mk(T_HT, 25'h11, 5'd5); arb_exp[1] = '0;
    arb_exp[2] = mk(T_HT, 25'h31, 5'd5); arb_exp[3] = '0;
    arb_exp[4] = mk(T_HT, 25'h12, 5'd5); arb_exp[5] = '0;
    arb_exp[6] = mk(T_HT, 25'h32, 5'd5); arb_exp[7] = '0;
    set_in(1, arb_exp[0]); set_in(3, arb_exp[2]); step();
    set_in(1, arb_exp[4]); set_in(3, arb_exp[6]); step();
    clr_in();
    for (int k = 0; k < 8; k++) begin
      step();
      check("arb_rr_valid", valid_out[0], (k % 2 == 0) ? 1'b1 : 1'b0);
      check("arb_rr_data", dout(0), arb_exp[k]);
      check("arb_fp_data", fp_dout(0), arb_exp[k]);
    end
    // Input 1 alone moves the round-robin pointer past it
    f = mk(T_HT, 25'h13, 5'd5);
    set_in(1, f); step(); clr_in(); step(); step();
    check("arb_solo_rr", dout(0), f);
    check("arb_solo_fp", fp_dout(0), f);
    step();
    // Simultaneous heads: round-robin favours 3, fixed priority favours 1
    set_in(1, mk(T_HT, 25'h14, 5'd5)); set_in(3, mk(T_HT, 25'h34, 5'd5)); step();
    clr_in(); step(); step();
    check("arb_tie_rr", dout(0), mk(T_HT, 25'h34, 5'd5));
    check("arb_tie_fp", fp_dout(0), mk(T_HT, 25'h14, 5'd5));
    step(); step();
    check("arb_next_rr", dout(0), mk(T_HT, 25'h14, 5'd5));
    check("arb_next_fp", fp_dout(0), mk(T_HT, 25'h34, 5'd5));
    step(); step();

    // Fill input 2 while its east route is stalled
    ready_out[2] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      set_in(2, mk(T_HT, 25'(16'h300 + j), 5'd7)); step();
      check("fill_ready_in2", ready_in[2], (j < 7) ? 1'b1 : 1'b0);
    end
    clr_in();
    ready_out[2] = 1'b1; step(); ready_out[2] = 1'b0;
    check("fill_after_pop", ready_in[2], 1'b1);
    ready_out[2] = 1'b1;
    repeat (40) step();
    check("fill_drained_ready", ready_in, 5'b11111);
    check("fill_drained_valid", valid_out, 0);

    // BODY at idle input 4 is dropped and flagged
    set_in(4, mk(T_BODY, 25'h400, 5'd7)); step();
    clr_in(); step();
    check("err_body_flag", err_out, 5'b10000);
    check("err_body_ready", ready_in, 5'b11111);
    repeat (3) step();
    check("err_body_sticky", err_out, 5'b10000);
    check("err_body_novalid", valid_out, 0);

    // Unroutable head (dest 16) and its trailing flits are dropped on input 3
    set_in(3, mk(T_HEAD, 25'h500, 5'd16)); step();
    set_in(3, mk(T_BODY, 25'h501, 5'd16)); step();
    set_in(3, mk(T_TAIL, 25'h502, 5'd16)); step();
    clr_in();
    for (int j = 0; j < 5; j++) begin
      step();
      check("err_dest_novalid", valid_out, 0);
    end
    check("err_dest_flags", err_out, 5'b11000);
    check("err_dest_ready", ready_in, 5'b11111);

    // Reset in the middle of a packet, then route a fresh one
    set_in(0, mk(T_HEAD, 25'h600, 5'd13)); step();
    set_in(0, mk(T_BODY, 25'h601, 5'd13)); step();
    clr_in(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_valid_out", valid_out, 0);
    check("rst2_ready_in", ready_in, 5'b11111);
    check("rst2_err_out", err_out, 0);
    check("rst2_data_out", data_out, 0);
    f = mk(T_HT, 25'h700, 5'd4);
    set_in(0, f); step(); clr_in(); step(); step();
    check("rst2_new_valid", valid_out, 5'b10000);
    check("rst2_new_data", dout(4), f);
    step();
    check("rst2_new_done", valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
